// File: rtl/proc_run_ctrl_if.sv
// Command, program-load and instruction-memory write signals between the pin
// interface and the run-control sequencer.
interface proc_run_ctrl_if #(
   parameter int unsigned INST_W = 8,
   parameter int unsigned PC_W   = 4
);
   logic              cmd_valid;
   logic [1:0]        cmd_op;
   logic              cmd_ready;
   logic              load_valid;
   logic [INST_W-1:0] load_data;
   logic              load_ready;
   logic              imem_we;
   logic [PC_W-1:0]   imem_waddr;
   logic [INST_W-1:0] imem_wdata;

   modport master (
      output cmd_valid, cmd_op, load_valid, load_data,
      input  cmd_ready, load_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  cmd_valid, cmd_op, load_valid, load_data,
      output cmd_ready, load_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run-control and program-load sequencer for the 8-bit accumulator core:
// loads imem, gates core execution (run/step/halt/breakpoint) and clears the core.
module proc_run_ctrl #(
   parameter int unsigned IMEM_DEPTH = 16,
   parameter int unsigned INST_W     = 8,
   parameter int unsigned PC_W       = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   proc_run_ctrl_if.slave   bus,
   input  logic [PC_W-1:0]  core_pc,
   input  logic             core_term,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   output logic             core_en,
   output logic             core_clr,
   output logic [2:0]       state_out,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CLEAR  = 3'd2,
      S_RUN    = 3'd3,
      S_STEP   = 3'd4,
      S_PAUSED = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [1:0]      OP_LOAD  = 2'b00;
   localparam logic [1:0]      OP_RUN   = 2'b01;
   localparam logic [1:0]      OP_STEP  = 2'b10;
   localparam logic [1:0]      OP_HALT  = 2'b11;
   localparam logic [PC_W-1:0] LAST_ADR = PC_W'(IMEM_DEPTH - 1);

   state_t          state_q, state_d;
   state_t          tgt_q, tgt_d;
   logic            skip_q;
   logic            waddr_clr;
   logic [PC_W-1:0] waddr_q;
   logic            cmd_acc;
   logic            byte_acc;
   logic            bp_hit;

   assign cmd_acc   = bus.cmd_valid & bus.cmd_ready;
   assign byte_acc  = bus.load_valid & bus.load_ready;
   // resume_skip lets the first RUN cycle after a pause execute the breakpoint word
   assign bp_hit    = bp_en & (core_pc == bp_addr) & ~skip_q;
   assign state_out = state_q;

   // State register, post-clear target and breakpoint resume flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tgt_q   <= S_IDLE;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         skip_q  <= (state_q == S_PAUSED) && (state_d == S_RUN);
      end
   end

   // Next-state logic; accepted commands not listed for a state are dropped
   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      waddr_clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_acc) begin
               case (bus.cmd_op)
                  OP_LOAD: begin
                     state_d   = S_LOAD;
                     waddr_clr = 1'b1;
                  end
                  OP_RUN: begin
                     state_d = S_CLEAR;
                     tgt_d   = S_RUN;
                  end
                  OP_STEP: state_d = S_STEP;
                  default: ;
               endcase
            end
         end
         S_LOAD: begin
            if (cmd_acc && (bus.cmd_op == OP_HALT)) begin
               state_d = S_IDLE;
            end else if (byte_acc && (waddr_q == LAST_ADR)) begin
               state_d = S_CLEAR;
               tgt_d   = S_IDLE;
            end
         end
         S_CLEAR: state_d = tgt_q;
         S_RUN: begin
            if (cmd_acc && (bus.cmd_op == OP_HALT)) begin
               state_d = S_CLEAR;
               tgt_d   = S_IDLE;
            end else if (bp_hit) begin
               state_d = S_PAUSED;
            end else if (core_term) begin
               state_d = S_DONE;
            end
         end
         S_STEP: state_d = core_term ? S_DONE : S_PAUSED;
         S_PAUSED: begin
            if (cmd_acc) begin
               case (bus.cmd_op)
                  OP_RUN:  state_d = S_RUN;
                  OP_STEP: state_d = S_STEP;
                  OP_HALT: begin
                     state_d = S_CLEAR;
                     tgt_d   = S_IDLE;
                  end
                  default: ;
               endcase
            end
         end
         S_DONE: begin
            if (cmd_acc) begin
               case (bus.cmd_op)
                  OP_RUN: begin
                     state_d = S_CLEAR;
                     tgt_d   = S_RUN;
                  end
                  OP_LOAD: begin
                     state_d   = S_LOAD;
                     waddr_clr = 1'b1;
                  end
                  OP_HALT: state_d = S_IDLE;
                  default: ;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State-decoded handshake and core control
   always_comb begin
      core_en        = 1'b0;
      core_clr       = 1'b0;
      bus.cmd_ready  = 1'b1;
      bus.load_ready = 1'b0;
      case (state_q)
         S_LOAD:  bus.load_ready = 1'b1;
         S_CLEAR: begin
            core_clr      = 1'b1;
            bus.cmd_ready = 1'b0;
         end
         S_RUN:   core_en = ~bp_hit;
         S_STEP:  core_en = 1'b1;
         default: ;
      endcase
   end

   // Imem write pipeline and saturating execution counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr_q        <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_waddr <= '0;
         bus.imem_wdata <= '0;
         cycle_cnt      <= '0;
      end else begin
         bus.imem_we <= byte_acc;
         if (byte_acc) begin
            bus.imem_waddr <= waddr_q;
            bus.imem_wdata <= INST_W'(bus.load_data);
         end
         if (waddr_clr) begin
            waddr_q <= '0;
         end else if (byte_acc) begin
            waddr_q <= waddr_q + PC_W'(1);
         end
         if (state_q == S_CLEAR) begin
            cycle_cnt <= '0;
         end else if (core_en && (cycle_cnt != {CNT_W{1'b1}})) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: imem writes checked through a scoreboard queue,
// run control exercised against a small core pc model.
module tb_proc_run_ctrl;
   localparam int unsigned PC_W   = 4;
   localparam int unsigned INST_W = 8;
   localparam int unsigned CNT_W  = 8;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [PC_W-1:0]  core_pc = '0;
   logic             core_term;
   logic             bp_en;
   logic [PC_W-1:0]  bp_addr;
   logic             core_en;
   logic             core_clr;
   logic [2:0]       state_out;
   logic [CNT_W-1:0] cycle_cnt;
   logic             term_allow;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int clr_cnt = 0;
   int en_cnt = 0;
   int w0, c0, e0;
   logic [11:0] sb[$];
   logic [11:0] sb_e;
   logic [7:0]  prog [16] = '{8'h1B, 8'h17, 8'h21, 8'h05, 8'h33, 8'h42, 8'h18, 8'h27,
                              8'h3C, 8'h0A, 8'h55, 8'h66, 8'h71, 8'h8E, 8'hF0, 8'h00};

   proc_run_ctrl_if #(.INST_W(INST_W), .PC_W(PC_W)) bus ();

   proc_run_ctrl #(.IMEM_DEPTH(16), .INST_W(INST_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .core_pc   (core_pc),
      .core_term (core_term),
      .bp_en     (bp_en),
      .bp_addr   (bp_addr),
      .core_en   (core_en),
      .core_clr  (core_clr),
      .state_out (state_out),
      .cycle_cnt (cycle_cnt)
   );

   always #5 clk = ~clk;

   // Core model: pc clears on core_clr, advances when enabled, freezes at the last word
   assign core_term = term_allow && (core_pc == 4'hF);
   always @(posedge clk) begin
      if (core_clr)                 core_pc <= '0;
      else if (core_en && !core_term) core_pc <= core_pc + 4'd1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor pops the scoreboard on each imem_we
   always @(negedge clk) begin
      if (core_clr) clr_cnt++;
      if (core_en)  en_cnt++;
      if (bus.imem_we) begin
         wr_cnt++;
         if (sb.size() == 0) begin
            check_val("imem_unexpected", 32'(bus.imem_waddr), 32'h100);
         end else begin
            sb_e = sb.pop_front();
            check_val("imem_addr", 32'(bus.imem_waddr), 32'(sb_e[11:8]));
            check_val("imem_data", 32'(bus.imem_wdata), 32'(sb_e[7:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic load_byte(input logic [3:0] a, input logic [7:0] d, input int gap);
      repeat (gap) tick();
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      sb.push_back({a, d});
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      for (int i = 0; i < budget && state_out != s; i++) tick();
      check_val(tag, 32'(state_out), 32'(s));
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'b00;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bp_en          = 1'b0;
      bp_addr        = '0;
      term_allow     = 1'b1;

      #12;
      check_val("rst_state", 32'(state_out), 32'd0);
      check_val("rst_cnt", 32'(cycle_cnt), 32'd0);
      check_val("rst_en", 32'(core_en), 32'd0);
      check_val("rst_clr", 32'(core_clr), 32'd0);
      check_val("rst_we", 32'(bus.imem_we), 32'd0);
      check_val("rst_load_ready", 32'(bus.load_ready), 32'd0);
      check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Full 16-byte program load with gaps
      send_cmd(OP_LOAD);
      check_val("load_state", 32'(state_out), 32'd1);
      check_val("load_ready", 32'(bus.load_ready), 32'd1);
      w0 = wr_cnt;
      c0 = clr_cnt;
      for (int i = 0; i < 16; i++) load_byte(4'(i), prog[i], i % 3);
      check_val("load_clear_state", 32'(state_out), 32'd2);
      check_val("load_clear_pulse", 32'(core_clr), 32'd1);
      tick();
      check_val("load_end_state", 32'(state_out), 32'd0);
      check_val("load_writes", 32'(wr_cnt - w0), 32'd16);
      check_val("load_clr_count", 32'(clr_cnt - c0), 32'd1);
      check_val("load_sb_empty", 32'(sb.size()), 32'd0);

      // Aborted load after five bytes
      send_cmd(OP_LOAD);
      w0 = wr_cnt;
      c0 = clr_cnt;
      for (int i = 0; i < 5; i++) load_byte(4'(i), 8'hA0 + 8'(i), 1);
      send_cmd(OP_HALT);
      tick();
      check_val("abort_state", 32'(state_out), 32'd0);
      check_val("abort_writes", 32'(wr_cnt - w0), 32'd5);
      check_val("abort_no_clr", 32'(clr_cnt - c0), 32'd0);
      check_val("abort_load_ready", 32'(bus.load_ready), 32'd0);
      check_val("abort_sb_empty", 32'(sb.size()), 32'd0);

      // Breakpoint at pc 6, resume through it to termination
      bp_en   = 1'b1;
      bp_addr = 4'd6;
      send_cmd(OP_RUN);
      wait_state("bp_pause", 3'd5, 50);
      check_val("bp_pc", 32'(core_pc), 32'd6);
      check_val("bp_en_low", 32'(core_en), 32'd0);
      check_val("bp_cnt", 32'(cycle_cnt), 32'd6);
      send_cmd(OP_RUN);
      check_val("resume_state", 32'(state_out), 32'd3);
      check_val("resume_skip_en", 32'(core_en), 32'd1);
      wait_state("run_done", 3'd6, 50);
      check_val("done_cnt", 32'(cycle_cnt), 32'd16);
      check_val("done_pc", 32'(core_pc), 32'd15);
      check_val("done_en_low", 32'(core_en), 32'd0);

      // Restart from DONE, pause again, then three single steps
      send_cmd(OP_RUN);
      wait_state("bp_pause2", 3'd5, 50);
      check_val("bp_cnt2", 32'(cycle_cnt), 32'd6);
      e0 = en_cnt;
      for (int i = 0; i < 3; i++) begin
         send_cmd(OP_STEP);
         check_val("step_state", 32'(state_out), 32'd4);
         check_val("step_en", 32'(core_en), 32'd1);
         tick();
         check_val("step_paused", 32'(state_out), 32'd5);
         check_val("step_en_low", 32'(core_en), 32'd0);
      end
      check_val("step_pulses", 32'(en_cnt - e0), 32'd3);
      check_val("step_cnt", 32'(cycle_cnt), 32'd9);
      check_val("step_pc", 32'(core_pc), 32'd9);
      send_cmd(OP_HALT);
      check_val("pause_halt_clr", 32'(core_clr), 32'd1);
      tick();
      check_val("pause_halt_idle", 32'(state_out), 32'd0);
      bp_en = 1'b0;

      // Counter saturation, then HALT clears it
      term_allow = 1'b0;
      send_cmd(OP_RUN);
      tick();
      check_val("sat_run_state", 32'(state_out), 32'd3);
      repeat (300) tick();
      check_val("sat_cnt", 32'(cycle_cnt), 32'd255);
      send_cmd(OP_HALT);
      check_val("sat_halt_clr", 32'(core_clr), 32'd1);
      check_val("sat_halt_state", 32'(state_out), 32'd2);
      tick();
      check_val("sat_cleared_cnt", 32'(cycle_cnt), 32'd0);
      check_val("sat_idle", 32'(state_out), 32'd0);
      check_val("sat_clr_low", 32'(core_clr), 32'd0);

      // Asynchronous reset in the middle of RUN
      send_cmd(OP_RUN);
      repeat (5) tick();
      check_val("pre_rst_state", 32'(state_out), 32'd3);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("arst_state", 32'(state_out), 32'd0);
      check_val("arst_cnt", 32'(cycle_cnt), 32'd0);
      check_val("arst_en", 32'(core_en), 32'd0);
      check_val("arst_clr", 32'(core_clr), 32'd0);
      check_val("arst_we", 32'(bus.imem_we), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      check_val("post_rst_state", 32'(state_out), 32'd0);
      check_val("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Run-control and program-load sequencer for the 8-bit accumulator core.
- Streams a 16-byte program into instruction memory through a write port.
- Gates core execution with run, single-step, halt and breakpoint, and issues a synchronous clear pulse to the core's pc and accumulator.
- Sits between the pin-level command interface and the core; the core's state updates only when core_en is high.

Parameters:
IMEM_DEPTH  16  instruction words per program load
INST_W      8   instruction width
PC_W        4   pc / imem address width
CNT_W       8   execution cycle counter width (saturating)

Ports:
clk          in   1        clock
rst_n        in   1        reset; asynchronous assert, active low
cmd_valid    in   1        command strobe
cmd_op       in   2        00 LOAD, 01 RUN, 10 STEP, 11 HALT
cmd_ready    out  1        command accepted when cmd_valid & cmd_ready
load_valid   in   1        program byte valid
load_data    in   INST_W   program byte
load_ready   out  1        byte accepted when load_valid & load_ready
core_pc      in   PC_W     current core pc
core_term    in   1        core terminated (pc frozen at last word)
bp_en        in   1        breakpoint enable
bp_addr      in   PC_W     breakpoint pc
imem_we      out  1        imem write strobe
imem_waddr   out  PC_W     imem write address
imem_wdata   out  INST_W   imem write data
core_en      out  1        core execute enable (pc/acc/dmem update)
core_clr     out  1        one-cycle synchronous clear of core pc/acc
state_out    out  3        encoded FSM state
cycle_cnt    out  CNT_W    executed cycles since last clear

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all registered outputs 0; cycle_cnt=0; load address=0.
- State encoding: IDLE=0, LOAD=1, CLEAR=2, RUN=3, STEP=4, PAUSED=5, DONE=6.
- cmd_ready is 1 in every state except CLEAR.
- An accepted command that is illegal in the current state is consumed and ignored.
- IDLE:
  - LOAD: waddr counter=0, go to LOAD.
  - RUN: go to CLEAR, with post-clear target RUN.
  - STEP: go to STEP.
  - HALT: no effect.
- LOAD:
  - load_ready=1.
  - Each accepted byte is registered: the following cycle drives imem_we=1 with imem_waddr=counter and imem_wdata=byte, then the counter increments.
  - Accepting byte IMEM_DEPTH-1 goes to CLEAR with target IDLE.
  - HALT in LOAD aborts to IDLE. Bytes already written stay written. No clear is issued.
  - An imem_we for a byte accepted in the abort cycle still issues.
- CLEAR:
  - Lasts exactly one cycle with core_clr=1, core_en=0.
  - Resets cycle_cnt to 0, then moves to the stored target.
- RUN:
  - core_en = ~bp_hit, combinational, where bp_hit = bp_en & (core_pc==bp_addr) & ~resume_skip.
  - bp_hit goes to PAUSED; that instruction is not executed.
  - resume_skip is set for the first RUN cycle after leaving PAUSED, so the run can leave the breakpoint address.
  - core_term sampled high goes to DONE. core_en stays high that cycle; the frozen core is harmless.
  - HALT goes to CLEAR with target IDLE.
  - bp_hit and core_term in the same cycle: PAUSED wins.
  - HALT in the same cycle as either: HALT wins.
- STEP:
  - One cycle with core_en=1, then PAUSED.
  - core_term high in that cycle goes to DONE instead.
- PAUSED:
  - core_en=0.
  - RUN goes to RUN with resume_skip.
  - STEP goes to STEP.
  - HALT goes to CLEAR with target IDLE.
- DONE:
  - core_en=0.
  - RUN goes to CLEAR with target RUN (restart).
  - LOAD goes to LOAD.
  - HALT goes to IDLE.
- cycle_cnt increments on every cycle where core_en=1, saturating at 2^CNT_W-1 with no wrap.
- load_ready=0 outside LOAD.
- imem_we is never asserted outside the cycle after an accepted byte.
- core_en and core_clr are never high together.

Test Plan:
- Reset mid-RUN: drop rst_n asynchronously, between clock edges. Outputs go to 0 immediately, state_out=0, cycle_cnt=0.
- LOAD then 16 bytes 0x1B,0x17,…,0x00 with load_valid gaps:
  - 16 imem_we pulses at addresses 0..15 with matching data.
  - Then one core_clr cycle, then state IDLE.
- LOAD, 5 bytes, then HALT:
  - Exactly 5 writes at addresses 0..4.
  - No core_clr; state IDLE; load_ready=0.
- RUN with bp_en=1, bp_addr=6, core pc model advancing:
  - Pauses with core_pc=6 and core_en=0; cycle_cnt=6.
  - RUN resumes past 6; core_term at pc 15 gives DONE.
- From PAUSED, issue STEP three times: exactly 3 single-cycle core_en pulses; cycle_cnt increases by 3.
- Hold core_term=0 in RUN for 300 cycles: cycle_cnt saturates at 255.
  - HALT gives core_clr, cycle_cnt=0, state IDLE.
